// File: rtl/des_key_sched.sv
// Iterative DES key schedule: PC-1 load, per-issue C/D rotation, PC-2 output.
// Issues the sixteen 48-bit round subkeys in encrypt or decrypt order over valid/ready.
module des_key_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:64] key_i,
  input  logic        decrypt_i,
  output logic [1:48] subkey_o,
  output logic        subkey_valid_o,
  input  logic        subkey_ready_i,
  output logic [3:0]  round_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned HALF_W = 28;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [1:HALF_W]    c_q, c_d, d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;

  logic [1:HALF_W]    pc1_c, pc1_d;
  logic [1:2*HALF_W]  cd;
  logic [1:48]        pc2;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               two_shift;
  logic               unused_parity;

  // Parity bits of the key never reach PC-1.
  assign unused_parity = ^{key_i[8], key_i[16], key_i[24], key_i[32],
                           key_i[40], key_i[48], key_i[56], key_i[64]};

  assign pc1_c = {key_i[57], key_i[49], key_i[41], key_i[33], key_i[25], key_i[17], key_i[9],
                  key_i[1],  key_i[58], key_i[50], key_i[42], key_i[34], key_i[26], key_i[18],
                  key_i[10], key_i[2],  key_i[59], key_i[51], key_i[43], key_i[35], key_i[27],
                  key_i[19], key_i[11], key_i[3],  key_i[60], key_i[52], key_i[44], key_i[36]};

  assign pc1_d = {key_i[63], key_i[55], key_i[47], key_i[39], key_i[31], key_i[23], key_i[15],
                  key_i[7],  key_i[62], key_i[54], key_i[46], key_i[38], key_i[30], key_i[22],
                  key_i[14], key_i[6],  key_i[61], key_i[53], key_i[45], key_i[37], key_i[29],
                  key_i[21], key_i[13], key_i[5],  key_i[28], key_i[20], key_i[12], key_i[4]};

  assign cd = {c_q, d_q};

  assign pc2 = {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
                cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
                cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
                cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
                cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
                cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
                cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
                cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};

  // 28-bit circular rotate by 1 or 2, left (encrypt) or right (decrypt).
  function automatic logic [1:HALF_W] rot(input logic [1:HALF_W] v,
                                           input logic right, input logic two);
    case ({right, two})
      2'b00:   rot = {v[2:28], v[1]};
      2'b01:   rot = {v[3:28], v[1:2]};
      2'b10:   rot = {v[28], v[1:27]};
      default: rot = {v[27:28], v[1:26]};
    endcase
  endfunction

  // Single-step issues are 1, 8 and 15; every other issue shifts by two.
  assign cnt_nxt   = cnt_q + CNT_W'(1);
  assign two_shift = !((cnt_nxt == CNT_W'(1)) || (cnt_nxt == CNT_W'(8)) ||
                       (cnt_nxt == CNT_W'(15)));

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          dir_d   = decrypt_i;
          cnt_d   = '0;
          if (decrypt_i) begin
            c_d = pc1_c;
            d_d = pc1_d;
          end else begin
            c_d = rot(pc1_c, 1'b0, 1'b0);
            d_d = rot(pc1_d, 1'b0, 1'b0);
          end
        end
      end
      RUN: begin
        if (subkey_ready_i) begin
          if (cnt_q == CNT_W'(15)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_nxt;
            c_d   = rot(c_q, dir_q, two_shift);
            d_d   = rot(d_q, dir_q, two_shift);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign busy_o         = (state_q == RUN);
  assign subkey_valid_o = busy_o;
  assign subkey_o       = busy_o ? pc2 : '0;
  assign round_o        = busy_o ? cnt_q : '0;
  assign done_o         = done_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Randomized scoreboard bench for des_key_sched against a table-driven FIPS 46-3 key schedule model.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:64] key_i;
  logic        decrypt_i;
  logic [1:48] subkey_o;
  logic        subkey_valid_o;
  logic        subkey_ready_i;
  logic [3:0]  round_o;
  logic        busy_o;
  logic        done_o;

  des_key_sched dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .key_i          (key_i),
    .decrypt_i      (decrypt_i),
    .subkey_o       (subkey_o),
    .subkey_valid_o (subkey_valid_o),
    .subkey_ready_i (subkey_ready_i),
    .round_o        (round_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                              10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                              63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                              14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                              16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                              44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  typedef struct packed {
    logic [47:0] key;
    logic [3:0]  rnd;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [47:0] seen [16];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // FIPS round rnd (1..16): cumulative left rotation applied to PC-1 halves, then PC-2.
  function automatic logic [47:0] ref_key(input logic [63:0] key, input int rnd);
    int          tot;
    bit          cd  [56];
    bit          cdr [56];
    logic [47:0] r;
    tot = 0;
    for (int i = 0; i < rnd; i++) tot += SHIFTS[i];
    for (int i = 0; i < 56; i++) cd[i] = key[64 - PC1[i]];
    for (int i = 0; i < 28; i++) begin
      cdr[i]      = cd[(i + tot) % 28];
      cdr[28 + i] = cd[28 + ((i + tot) % 28)];
    end
    r = '0;
    for (int j = 0; j < 48; j++) r = {r[46:0], cdr[PC2[j] - 1]};
    return r;
  endfunction

  // Monitor: every accepted subkey is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (subkey_valid_o && subkey_ready_i) begin
        chk("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("subkey", 64'(subkey_o), 64'(mon_e.key));
          chk("round", 64'(round_o), 64'(mon_e.rnd));
          seen[round_o] = subkey_o;
        end
      end else if (!subkey_valid_o) begin
        chk("idle_outputs_zero", 64'({subkey_o, round_o}), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a run in the current cycle; returns in the done_o cycle (or after a reset abort).
  task automatic run_seq(input logic [63:0] key, input logic [63:0] exp_key, input bit dec,
                         input int stall_rnd, input int stall_len, input int pulse_rnd,
                         input int rst_rnd, input bit chk_end);
    int          cyc;
    bit          got_done, stalled, pulsed;
    logic [47:0] hold;
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{key: ref_key(exp_key, dec ? 16 - i : i + 1), rnd: 4'(i)});
    key_i     = key;
    decrypt_i = dec;
    start_i   = 1'b1;
    step();
    start_i   = 1'b0;
    cyc       = 1;
    chk("start_busy", 64'(busy_o), 64'd1);
    chk("start_valid", 64'(subkey_valid_o), 64'd1);
    got_done = 0; stalled = 0; pulsed = 0;
    while (cyc < 80) begin
      if (done_o) begin
        got_done = 1;
        break;
      end
      if (rst_rnd >= 0 && subkey_valid_o && int'(round_o) == rst_rnd) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_outputs_zero", 64'({subkey_o, round_o, subkey_valid_o, busy_o, done_o}), 64'd0);
        exp_q.delete();
        step();
        chk("rst_no_done", 64'({done_o, busy_o}), 64'd0);
        return;
      end
      if (stall_len > 0 && !stalled && subkey_valid_o && int'(round_o) == stall_rnd) begin
        stalled = 1;
        hold    = subkey_o;
        subkey_ready_i = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          cyc++;
          chk("stall_subkey", 64'(subkey_o), 64'(hold));
          chk("stall_round", 64'(round_o), 64'(stall_rnd));
        end
        subkey_ready_i = 1'b1;
        continue;
      end
      if (pulse_rnd >= 0 && !pulsed && subkey_valid_o && int'(round_o) == pulse_rnd) begin
        pulsed    = 1;
        start_i   = 1'b1;
        key_i     = ~key;
        decrypt_i = ~dec;
        step();
        cyc++;
        start_i = 1'b0;
        continue;
      end
      step();
      cyc++;
    end
    chk("done_seen", 64'(got_done), 64'd1);
    if (got_done) begin
      chk("done_cycle", 64'(cyc), 64'(17 + (stall_len > 0 ? stall_len : 0)));
      chk("done_busy_low", 64'({busy_o, subkey_valid_o}), 64'd0);
      chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
    end
    if (chk_end) begin
      step();
      chk("done_pulse_width", 64'(done_o), 64'd0);
    end
  endtask

  localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B  = 64'h123456789ABCDEF0;
  localparam logic [63:0] PARITY = 64'h0101010101010101;

  initial begin
    logic [63:0] rk;
    bit          rd;
    int          sr, sl;
    rst = 1'b1; start_i = 1'b0; key_i = '0; decrypt_i = 1'b0; subkey_ready_i = 1'b1;
    step(); step(); step();
    chk("reset_outputs", 64'({subkey_o, round_o, subkey_valid_o, busy_o, done_o}), 64'd0);
    rst = 1'b0;
    step();
    chk("post_reset_outputs", 64'({subkey_o, round_o, subkey_valid_o, busy_o, done_o}), 64'd0);

    run_seq(KEY_A, KEY_A, 1'b0, -1, 0, -1, -1, 1'b1);
    chk("kat_enc_r0", 64'(seen[0]), 64'h1B02EFFC7072);
    chk("kat_enc_r1", 64'(seen[1]), 64'h79AED9DBC9E5);
    chk("kat_enc_r15", 64'(seen[15]), 64'hCB3D8B0E17F5);

    run_seq(KEY_A, KEY_A, 1'b1, -1, 0, -1, -1, 1'b1);
    chk("kat_dec_r0", 64'(seen[0]), 64'hCB3D8B0E17F5);
    chk("kat_dec_r14", 64'(seen[14]), 64'h79AED9DBC9E5);
    chk("kat_dec_r15", 64'(seen[15]), 64'h1B02EFFC7072);

    run_seq(KEY_A, KEY_A, 1'b0, 3, 5, -1, -1, 1'b1);

    run_seq(KEY_A ^ PARITY, KEY_A, 1'b0, -1, 0, -1, -1, 1'b1);
    run_seq(KEY_B ^ PARITY, KEY_B, 1'b0, -1, 0, -1, -1, 1'b1);
    run_seq(KEY_B ^ PARITY, KEY_B, 1'b1, -1, 0, -1, -1, 1'b1);

    run_seq(KEY_A, KEY_A, 1'b0, -1, 0, -1, 7, 1'b0);
    run_seq(KEY_A, KEY_A, 1'b0, -1, 0, -1, -1, 1'b1);
    chk("kat_after_rst_r0", 64'(seen[0]), 64'h1B02EFFC7072);

    run_seq(KEY_A, KEY_A, 1'b0, -1, 0, 5, -1, 1'b0);
    run_seq(KEY_A, KEY_A, 1'b1, -1, 0, -1, -1, 1'b1);
    chk("b2b_dec_r0", 64'(seen[0]), 64'hCB3D8B0E17F5);

    for (int n = 0; n < 8; n++) begin
      rk = {$urandom, $urandom};
      rd = 1'($urandom_range(0, 1));
      sr = $urandom_range(0, 15);
      sl = (n % 2 == 0) ? $urandom_range(1, 4) : 0;
      run_seq(rk, rk, rd, sr, sl, -1, -1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
